// File: rtl/mem_unit_pkg.sv
// Shared definitions for the latch-memory sequencing controller.
//   - state_e     : controller state encoding (6 states, 3-bit)
//   - OP_READ/OP_WRITE : memory unit op encoding
//   - MEM_*       : geometry of the 8-word x 8-bit latch array
//   - mem_req_t   : op/address/data payload held toward the memory unit
package mem_unit_pkg;

  localparam int unsigned MEM_DEPTH  = 8;
  localparam int unsigned MEM_ADDR_W = 3;
  localparam int unsigned MEM_DATA_W = 8;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_WPULSE = 3'd2,
    ST_WHOLD  = 3'd3,
    ST_RWAIT  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Payload presented to the memory unit; held stable around every select pulse.
  typedef struct packed {
    logic                  op;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

endpackage : mem_unit_pkg

// File: rtl/mem_unit_ctrl.sv
// Sequencing controller for the 8-word x 8-bit latch-based memory unit.
// Accepts one valid/ready request at a time, drives op/address/in_bus with a
// setup cycle, a select pulse and a hold cycle, captures out_bus on reads and
// returns a valid/ready response.
//
// Ports:
//   clk, rst_n             : clock (rising edge), async active-low reset
//   req_valid/req_ready    : request handshake (req_ready high only in IDLE)
//   req_we/addr/wdata      : request payload (1 = write)
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata              : read data, 0x00 for write responses
//   mem_op/select/address/in_bus : registered drive to the memory unit
//   mem_out_bus            : read data from the memory unit
module mem_unit_ctrl
  import mem_unit_pkg::*;
#(
  parameter int unsigned WR_PULSE_CYC = 2,
  parameter int unsigned RD_WAIT_CYC  = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [MEM_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [MEM_DATA_W-1:0] rsp_rdata,
  output logic                  mem_op,
  output logic                  mem_select,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [MEM_DATA_W-1:0] mem_in_bus,
  input  logic [MEM_DATA_W-1:0] mem_out_bus
);

  // Terminal counts of the select phases (counter runs 0 .. N-1).
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  mem_req_t               req_q, req_d;
  logic                   sel_q, sel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [MEM_DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  // State and output registers; reset drops select asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      sel_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state and next-output decode. select is computed one cycle ahead so
  // that the registered pulse lines up exactly with WPULSE / RWAIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    sel_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.op   = req_we ? OP_WRITE : OP_READ;
          req_d.addr = req_addr;
          req_d.data = req_wdata;
          state_d    = ST_SETUP;
        end
      end

      // Payload has been stable for one cycle; open the select pulse.
      ST_SETUP: begin
        cnt_d   = '0;
        sel_d   = 1'b1;
        state_d = (req_q.op == OP_WRITE) ? ST_WPULSE : ST_RWAIT;
      end

      ST_WPULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_WHOLD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          sel_d = 1'b1;
        end
      end

      // Hold cycle after the write pulse; payload still driven.
      ST_WHOLD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        state_d     = ST_RESP;
      end

      // out_bus is sampled on the edge that closes the select pulse.
      ST_RWAIT: begin
        if (cnt_q == RD_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_out_bus;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          sel_d = 1'b1;
        end
      end

      // Address and data are left as-is; only op is returned to read.
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_d.op    = OP_READ;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_op      = req_q.op;
  assign mem_select  = sel_q;
  assign mem_address = req_q.addr;
  assign mem_in_bus  = req_q.data;

endmodule : mem_unit_ctrl

// File: tb/tb_mem_unit_ctrl.sv
// Bench for mem_unit_ctrl: instance 0 uses default timing, instance 1 uses
// WR_PULSE_CYC = 4 / RD_WAIT_CYC = 3. Each drives a behavioural latch array.
module tb_mem_unit_ctrl;

  logic clk;
  logic rst_n;

  logic       req_valid   [2];
  logic       req_ready   [2];
  logic       req_we      [2];
  logic [2:0] req_addr    [2];
  logic [7:0] req_wdata   [2];
  logic       rsp_valid   [2];
  logic       rsp_ready   [2];
  logic [7:0] rsp_rdata   [2];
  logic       mem_op      [2];
  logic       mem_select  [2];
  logic [2:0] mem_address [2];
  logic [7:0] mem_in_bus  [2];
  logic [7:0] mem_out_bus [2];

  logic [7:0] mem_m [2][8];

  int n_total;
  int n_pass;

  // Monitor state (written only by the monitor process).
  int          hcnt       [2];
  int          last_width [2];
  int          npulses    [2];
  int          viol       [2];
  logic        prev_sel   [2];
  logic [11:0] prev_pay   [2];
  logic [11:0] cur_pay;

  typedef struct {
    int         inst;
    bit         we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         lat;
    int         width;
    int         bp;
  } vec_t;

  vec_t vecs[$];

  mem_unit_ctrl u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .rsp_valid  (rsp_valid[0]),
    .rsp_ready  (rsp_ready[0]),
    .rsp_rdata  (rsp_rdata[0]),
    .mem_op     (mem_op[0]),
    .mem_select (mem_select[0]),
    .mem_address(mem_address[0]),
    .mem_in_bus (mem_in_bus[0]),
    .mem_out_bus(mem_out_bus[0])
  );

  mem_unit_ctrl #(.WR_PULSE_CYC(4), .RD_WAIT_CYC(3), .CNT_W(4)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .rsp_valid  (rsp_valid[1]),
    .rsp_ready  (rsp_ready[1]),
    .rsp_rdata  (rsp_rdata[1]),
    .mem_op     (mem_op[1]),
    .mem_select (mem_select[1]),
    .mem_address(mem_address[1]),
    .mem_in_bus (mem_in_bus[1]),
    .mem_out_bus(mem_out_bus[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory arrays: written while select & op, read combinationally.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_select[i] && mem_op[i]) mem_m[i][mem_address[i]] <= mem_in_bus[i];
    end
  end
  assign mem_out_bus[0] = mem_m[0][mem_address[0]];
  assign mem_out_bus[1] = mem_m[1][mem_address[1]];

  // Select pulse width and payload stability around each pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cur_pay = {mem_op[i], mem_address[i], mem_in_bus[i]};
      if (!rst_n) begin
        hcnt[i] = 0;
      end else begin
        if ((mem_select[i] || prev_sel[i]) && cur_pay != prev_pay[i]) viol[i]++;
        if (mem_select[i]) begin
          hcnt[i]++;
        end else if (hcnt[i] != 0) begin
          last_width[i] = hcnt[i];
          npulses[i]++;
          hcnt[i] = 0;
        end
      end
      prev_sel[i] = rst_n ? mem_select[i] : 1'b0;
      prev_pay[i] = cur_pay;
    end
  end

  task automatic check(input bit ok, input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  // One full request/response transaction with optional response backpressure.
  task automatic do_txn(input vec_t v, input int idx);
    int  i;
    int  k;
    int  np0;
    bit  got;
    i = v.inst;
    @(negedge clk);
    check(req_ready[i] == 1'b1, "ready_idle", idx, 32'(req_ready[i]), 32'd1);
    np0          = npulses[i];
    req_valid[i] = 1'b1;
    req_we[i]    = v.we;
    req_addr[i]  = v.addr;
    req_wdata[i] = v.wdata;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    got = 1'b0;
    k   = 0;
    while (!got && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (rsp_valid[i]) got = 1'b1;
    end
    check(got && k == v.lat, "latency", idx, 32'(k), 32'(v.lat));
    for (int c = 0; c <= v.bp; c++) begin
      check(rsp_valid[i] && !req_ready[i] && rsp_rdata[i] == v.exp_rdata,
            "rsp_hold", idx, 32'(rsp_rdata[i]), 32'(v.exp_rdata));
      if (c < v.bp) begin
        // A competing request while busy must be ignored.
        req_valid[i] = 1'b1;
        req_we[i]    = ~v.we;
        req_addr[i]  = v.addr + 3'd1;
        req_wdata[i] = ~v.wdata;
        @(posedge clk); #1;
      end
    end
    req_valid[i] = 1'b0;
    rsp_ready[i] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[i] = 1'b0;
    check(!rsp_valid[i] && req_ready[i] && mem_op[i] == 1'b0, "handshake", idx,
          32'({rsp_valid[i], req_ready[i], mem_op[i]}), 32'h2);
    check((npulses[i] - np0) == 1 && last_width[i] == v.width, "sel_width", idx,
          32'(last_width[i]), 32'(v.width));
  endtask

  initial begin
    vec_t v;
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = 3'd0;
      req_wdata[i] = 8'h00; rsp_ready[i] = 1'b0;
      last_width[i] = 0; npulses[i] = 0; viol[i] = 0;
      prev_sel[i] = 1'b0; prev_pay[i] = 12'h0;
    end

    // Vector table: {inst, we, addr, wdata, exp_rdata, latency, sel width, backpressure}
    vecs.push_back('{0, 1'b1, 3'd3, 8'hA5, 8'h00, 4, 2, 0});
    vecs.push_back('{0, 1'b0, 3'd3, 8'h00, 8'hA5, 2, 1, 3});
    vecs.push_back('{0, 1'b1, 3'd7, 8'h3C, 8'h00, 4, 2, 1});
    for (int a = 0; a < 8; a++)
      vecs.push_back('{0, 1'b1, 3'(a), 8'(8'h10 + a), 8'h00, 4, 2, 0});
    for (int a = 0; a < 8; a++)
      vecs.push_back('{0, 1'b0, 3'(a), 8'h00, 8'(8'h10 + a), 2, 1, 0});
    vecs.push_back('{1, 1'b1, 3'd2, 8'h5A, 8'h00, 6, 4, 0});
    vecs.push_back('{1, 1'b0, 3'd2, 8'h00, 8'h5A, 4, 3, 2});
    vecs.push_back('{1, 1'b1, 3'd0, 8'hC3, 8'h00, 6, 4, 1});
    vecs.push_back('{1, 1'b0, 3'd0, 8'h00, 8'hC3, 4, 3, 0});

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check(!mem_select[i] && !mem_op[i] && mem_address[i] == 3'd0 && mem_in_bus[i] == 8'h00,
            "reset_mem", i, 32'({mem_select[i], mem_op[i], mem_address[i], mem_in_bus[i]}), 32'h0);
      check(!rsp_valid[i] && rsp_rdata[i] == 8'h00 && req_ready[i], "reset_rsp", i,
            32'({rsp_valid[i], rsp_rdata[i], req_ready[i]}), 32'h1);
    end
    rst_n = 1'b1;

    // rsp_ready while no response is pending has no effect
    rsp_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check(req_ready[0] && !rsp_valid[0] && !mem_select[0], "idle_rsp_ready", 0,
          32'({req_ready[0], rsp_valid[0], mem_select[0]}), 32'h4);
    rsp_ready[0] = 1'b0;

    foreach (vecs[n]) do_txn(vecs[n], n);

    // Reset asserted in the middle of a write pulse
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 3'd5; req_wdata[0] = 8'hEE;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    check(mem_select[0] == 1'b1, "midwrite_sel", 0, 32'(mem_select[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check(!mem_select[0] && !mem_op[0] && mem_address[0] == 3'd0 && mem_in_bus[0] == 8'h00,
          "async_reset_mem", 0, 32'({mem_select[0], mem_op[0], mem_address[0], mem_in_bus[0]}), 32'h0);
    check(!rsp_valid[0] && rsp_rdata[0] == 8'h00, "async_reset_rsp", 0,
          32'({rsp_valid[0], rsp_rdata[0]}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check(req_ready[0] && !mem_select[0] && !rsp_valid[0], "post_reset_ready", 0,
          32'({req_ready[0], mem_select[0], rsp_valid[0]}), 32'h4);

    v = '{0, 1'b0, 3'd0, 8'h00, 8'h10, 2, 1, 0};
    do_txn(v, 100);

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check(viol[i] == 0, "payload_stable", i, 32'(viol[i]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_unit_ctrl
